// File: rtl/vx_perf_stall_ctrl_pkg.sv
// Shared constants and types for the stall counter block.
// Unit indices, default counter width and FSM states.
package vx_perf_stall_ctrl_pkg;

  localparam int PERF_CTR_BITS = 44;

  localparam int UNIT_TEX    = 0;
  localparam int UNIT_RASTER = 1;
  localparam int UNIT_ROP    = 2;
  localparam int UNIT_IMADD  = 3;
  localparam int UNIT_WCTL   = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RSP  = 1'b1
  } stall_state_t;

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_perf_stall_ctrl_ctr.sv
// One stall counter with clear-then-count and sticky overflow.
// clr_all dominates everything, including the local clear.
module vx_perf_stall_ctrl_ctr #(
  parameter int CTR_BITS = 44
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  input  logic                clr,
  input  logic                clr_all,
  output logic [CTR_BITS-1:0] count,
  output logic                ovf
);

  logic wrap;

  assign wrap = inc & (&count);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr_all) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= inc ? CTR_BITS'(1) : '0;
      ovf   <= 1'b0;
    end else if (inc) begin
      count <= count + 1'b1;
      if (wrap)
        ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/vx_perf_stall_ctrl.sv
// Per-unit stall counters with a one-deep snapshot read port.
// Snapshots use pre-edge values, so same-cycle clears are not seen.
module vx_perf_stall_ctrl
  import vx_perf_stall_ctrl_pkg::*;
#(
  parameter  int NUM_UNITS = 5,
  parameter  int CTR_BITS  = PERF_CTR_BITS,
  localparam int IDX_BITS  = idx_bits(NUM_UNITS)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [NUM_UNITS-1:0]          stall_in,
  input  logic                          clear_all,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [IDX_BITS-1:0]           req_idx,
  input  logic                          req_clear,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [CTR_BITS-1:0]           rsp_data,
  output logic                          rsp_ovf,
  output logic                          rsp_err,
  output logic [NUM_UNITS*CTR_BITS-1:0] stalls_o
);

  stall_state_t state, state_n;

  logic [CTR_BITS-1:0] cnt [NUM_UNITS];
  logic [NUM_UNITS-1:0] ovf;
  logic                 accept;
  logic                 idx_ok;
  logic [CTR_BITS-1:0]  sel_data;
  logic                 sel_ovf;

  assign accept = (state == ST_IDLE) & req_valid;
  assign idx_ok = int'(req_idx) < NUM_UNITS;

  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_ctr
    logic clr;

    assign clr = accept & req_clear & idx_ok
               & (req_idx == IDX_BITS'(i));

    vx_perf_stall_ctrl_ctr #(
      .CTR_BITS(CTR_BITS)
    ) u_ctr (
      .clk    (clk),
      .rst_n  (reset_n),
      .inc    (enable & stall_in[i]),
      .clr    (clr),
      .clr_all(clear_all),
      .count  (cnt[i]),
      .ovf    (ovf[i])
    );

    assign stalls_o[i*CTR_BITS +: CTR_BITS] = cnt[i];
  end

  always_comb begin
    sel_data = '0;
    sel_ovf  = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (req_idx == IDX_BITS'(i)) begin
        sel_data = cnt[i];
        sel_ovf  = ovf[i];
      end
    end
  end

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_n = ST_RSP;
      end
      ST_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready)
          state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= ST_IDLE;
    else
      state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data <= '0;
      rsp_ovf  <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (accept) begin
      rsp_data <= idx_ok ? sel_data : '0;
      rsp_ovf  <= idx_ok & sel_ovf;
      rsp_err  <= ~idx_ok;
    end
  end

endmodule

// File: tb/tb_vx_perf_stall_ctrl.sv
// Directed bench for vx_perf_stall_ctrl with 4-bit counters.
// Expected values are hand-computed per step.
module tb_vx_perf_stall_ctrl;

  localparam int NU = 5;
  localparam int CB = 4;
  localparam int IB = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [NU-1:0] stall_in;
  logic          clear_all;
  logic          req_valid;
  logic          req_ready;
  logic [IB-1:0] req_idx;
  logic          req_clear;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [CB-1:0] rsp_data;
  logic          rsp_ovf;
  logic          rsp_err;
  logic [NU*CB-1:0] stalls_o;

  int total = 0;
  int bad   = 0;

  vx_perf_stall_ctrl #(
    .NUM_UNITS(NU),
    .CTR_BITS (CB)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable   (enable),
    .stall_in (stall_in),
    .clear_all(clear_all),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_idx  (req_idx),
    .req_clear(req_clear),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_ovf  (rsp_ovf),
    .rsp_err  (rsp_err),
    .stalls_o (stalls_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] unit(input int i);
    return stalls_o[i*CB +: CB];
  endfunction

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    stall_in  = '0;
    clear_all = 1'b0;
    req_valid = 1'b0;
    req_idx   = '0;
    req_clear = 1'b0;
    rsp_ready = 1'b0;
    #13;
    chk("rst_stalls", 32'(stalls_o), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_valid", 32'(rsp_valid), 32'h0);
    chk("rst_data", 32'(rsp_data), 32'h0);
    step();
    reset_n = 1'b1;

    enable   = 1'b1;
    stall_in = 5'b00100;
    repeat (10) step();
    stall_in = '0;
    chk("u2_ten", 32'(stalls_o), 32'h00A00);
    chk("u2_ready", 32'(req_ready), 32'h1);

    stall_in = 5'b01000;
    repeat (7) step();
    chk("u3_seven", 32'(unit(3)), 32'h7);
    req_valid = 1'b1;
    req_idx   = 3'd3;
    req_clear = 1'b1;
    step();
    req_valid = 1'b0;
    req_clear = 1'b0;
    stall_in  = '0;
    chk("clr_valid", 32'(rsp_valid), 32'h1);
    chk("clr_data", 32'(rsp_data), 32'h7);
    chk("clr_err", 32'(rsp_err), 32'h0);
    chk("clr_busy", 32'(req_ready), 32'h0);
    chk("clr_u3", 32'(unit(3)), 32'h1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("ret_ready", 32'(req_ready), 32'h1);
    chk("ret_valid", 32'(rsp_valid), 32'h0);

    stall_in = 5'b00001;
    repeat (15) step();
    chk("u0_max", 32'(unit(0)), 32'hF);
    step();
    stall_in = '0;
    chk("u0_wrap", 32'(unit(0)), 32'h0);
    req_valid = 1'b1;
    req_idx   = 3'd0;
    step();
    req_valid = 1'b0;
    chk("ovf_data", 32'(rsp_data), 32'h0);
    chk("ovf_flag", 32'(rsp_ovf), 32'h1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    req_valid = 1'b1;
    req_idx   = 3'd6;
    req_clear = 1'b1;
    step();
    req_valid = 1'b0;
    req_clear = 1'b0;
    chk("err_flag", 32'(rsp_err), 32'h1);
    chk("err_data", 32'(rsp_data), 32'h0);
    chk("err_ovf", 32'(rsp_ovf), 32'h0);
    chk("err_nochg", 32'(stalls_o), 32'h01A00);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    stall_in  = 5'b00010;
    req_valid = 1'b1;
    req_idx   = 3'd2;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_data", 32'(rsp_data), 32'hA);
      chk("hold_busy", 32'(req_ready), 32'h0);
      chk("hold_vld", 32'(rsp_valid), 32'h1);
    end
    chk("hold_u1", 32'(unit(1)), 32'h6);
    stall_in  = '0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    stall_in = 5'b00010;
    repeat (3) step();
    stall_in = '0;
    chk("u1_nine", 32'(unit(1)), 32'h9);
    stall_in  = 5'b11111;
    clear_all = 1'b1;
    req_valid = 1'b1;
    req_idx   = 3'd1;
    req_clear = 1'b1;
    step();
    stall_in  = '0;
    clear_all = 1'b0;
    req_valid = 1'b0;
    req_clear = 1'b0;
    chk("ca_data", 32'(rsp_data), 32'h9);
    chk("ca_valid", 32'(rsp_valid), 32'h1);
    chk("ca_zero", 32'(stalls_o), 32'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_idx   = 3'd0;
    step();
    req_valid = 1'b0;
    chk("ca_ovf", 32'(rsp_ovf), 32'h0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    enable   = 1'b0;
    stall_in = 5'b11111;
    repeat (3) step();
    chk("dis_hold", 32'(stalls_o), 32'h0);

    enable   = 1'b1;
    stall_in = 5'b10000;
    repeat (3) step();
    stall_in = '0;
    chk("u4_three", 32'(unit(4)), 32'h3);
    req_valid = 1'b1;
    req_idx   = 3'd4;
    step();
    req_valid = 1'b0;
    chk("mid_data", 32'(rsp_data), 32'h3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mr_valid", 32'(rsp_valid), 32'h0);
    chk("mr_ready", 32'(req_ready), 32'h1);
    chk("mr_stalls", 32'(stalls_o), 32'h0);
    chk("mr_data", 32'(rsp_data), 32'h0);
    step();
    reset_n = 1'b1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vx_perf_stall_ctrl.md
VX_PERF_STALL_CTRL -- requirements
Module: VX_perf_stall_ctrl

Interface
REQ-001 SHALL have parameter NUM_UNITS, default 5, number of stall sources (index 0 tex, 1 raster, 2 rop, 3 imadd, 4 wctl).
REQ-002 SHALL have parameter CTR_BITS, default `PERF_CTR_BITS, counter width.
REQ-003 SHALL have localparam IDX_BITS = max(1, clog2(NUM_UNITS)).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Ports, in order:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  counting enable
- stall_in  in  NUM_UNITS  per-unit stall event, one per cycle
- clear_all  in  1  single-cycle pulse, zero all counters
- req_valid  in  1  read request valid
- req_ready  out  1  request accepted when valid&ready
- req_idx  in  IDX_BITS  unit to read
- req_clear  in  1  clear the selected counter on accept
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_data  out  CTR_BITS  counter snapshot
- rsp_ovf  out  1  sticky overflow flag of the selected unit at snapshot
- rsp_err  out  1  req_idx >= NUM_UNITS
- stalls_o  out  NUM_UNITS*CTR_BITS  live counters, unit i at bits [i*CTR_BITS +: CTR_BITS]

Function
REQ-006 Counter i SHALL increment by 1 on each rising edge where enable=1 and stall_in[i]=1, modulo 2^CTR_BITS.
REQ-007 On a wrap from all-ones to 0, ovf[i] SHALL be set and stay set until cleared.
REQ-008 The FSM SHALL have two states: IDLE and RSP. Reset state is IDLE.
REQ-009 req_ready SHALL be 1 only in IDLE, combinationally from state.
REQ-010 On an accept edge (IDLE, req_valid=1), the block SHALL register rsp_data and rsp_ovf from the pre-edge counter[req_idx] and ovf[req_idx], set rsp_err, and move to RSP.
REQ-011 In RSP, rsp_valid SHALL be 1. rsp_data, rsp_ovf and rsp_err SHALL hold stable until the edge where rsp_ready=1, then the FSM SHALL return to IDLE.
REQ-012 Latency SHALL be one cycle from accept to rsp_valid, with at most one request accepted per two cycles.
REQ-013 If req_clear=1 at accept, counter[req_idx] SHALL load (enable&stall_in[req_idx]) ? 1 : 0 and ovf[req_idx] SHALL load 0 (clear then count).
REQ-014 If req_idx >= NUM_UNITS, the response SHALL give rsp_data=0, rsp_ovf=0, rsp_err=1; no counter changes and req_clear is ignored.
REQ-015 When clear_all=1, all counters and ovf flags SHALL load 0. clear_all SHALL win over same-cycle increments and over req_clear.
REQ-016 clear_all SHALL NOT affect the FSM or an in-flight response; a snapshot taken in the same cycle returns the pre-clear value.
REQ-017 With enable=0, counters SHALL hold, while reads, req_clear and clear_all still operate.
REQ-018 stalls_o SHALL be driven directly from the counter registers with no extra latency.
REQ-019 rsp_valid SHALL never be asserted in IDLE, and req_ready SHALL never be asserted in RSP.

Reset
REQ-020 On reset_n=0, independent of clk, all counters, all ovf flags, rsp_data, rsp_ovf and rsp_err SHALL be 0, the FSM SHALL be IDLE, and rsp_valid SHALL be 0 (so req_ready=1).
REQ-021 Reset asserted mid-response SHALL drop the response; no counter state survives.
REQ-022 Reset deassertion SHALL be synchronised externally; the block holds state until the first clk edge after release.

Structure
REQ-023 Unit-index constants (TEX, RASTER, ROP, IMADD, WCTL) and the FSM state enum SHALL live in the shared VX_gpu_pkg.
REQ-024 The per-unit counter SHALL be one sub-module, VX_perf_stall_ctr (increment, clear, sticky ovf), instantiated NUM_UNITS times.
REQ-025 Read-mux and FSM logic SHALL be in the top module only.

Verification
REQ-026 Reset, then enable=1 and stall_in=5'b00100 for 10 cycles -> stalls_o unit2=10, all other units 0, req_ready=1.
REQ-027 Counter3=7, request idx=3 with req_clear=1 and stall_in[3]=1 in the accept cycle -> rsp_data=7 one cycle later, and counter3=1 afterwards.
REQ-028 CTR_BITS=4, counter0=15, one stall -> counter0=0, then read idx=0 -> rsp_data=0, rsp_ovf=1.
REQ-029 Read idx=6 -> rsp_err=1, rsp_data=0, with no counter changed.
REQ-030 Hold rsp_ready=0 for 5 cycles while stalls continue -> rsp_data stable, req_ready=0, and the live counters still advance.
REQ-031 clear_all pulses in the same cycle as an accept of idx=1 (counter1=9) -> rsp_data=9, and all counters are 0 on the next cycle.
